// File: rtl/score_counter.sv
// -----------------------------------------------------------------------------
// score_counter
//
// Two-digit BCD score keeper driven by three raw push buttons.
// Each button is synchronized and debounced, and only the press edge counts as
// an event. An event applies one of three operations to the score:
// clear to 00, increment, or decrement. The score wraps decimally between 00
// and 99. The score is also encoded for two active-low seven-segment digits.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized cycles a new button level must
//                     hold before it is accepted (1 .. 2^20-1)
//   BLANK_LEADING   : 1 = blank the tens digit when it is 0
//
// Ports
//   clk     : sole clock; all state changes on the rising edge
//   reset   : synchronous reset, active-high
//   btn_inc : raw asynchronous increment button, high = pressed
//   btn_dec : raw asynchronous decrement button, high = pressed
//   btn_clr : raw asynchronous clear button, high = pressed
//   count   : registered BCD score {tens, ones}, 00..99
//   seg0    : registered ones-digit pattern {g,f,e,d,c,b,a}, active-low
//   seg1    : registered tens-digit pattern, same format (blankable)
// -----------------------------------------------------------------------------
module score_counter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLANK_LEADING   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    output logic [7:0] count,
    output logic [6:0] seg0,
    output logic [6:0] seg1
);

    // Button lanes: bit 0 = inc, bit 1 = dec, bit 2 = clr.
    localparam int NUM_BTN = 3;
    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_CLR = 2;

    // The last count value before an accepted level flip.
    localparam logic [19:0] DEB_LAST_C = 20'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK_C = 7'b1111111;
    localparam logic [6:0] SEG_ZERO_C  = 7'b1000000;
    localparam logic [6:0] SEG1_RST_C  = (BLANK_LEADING != 0) ? SEG_BLANK_C : SEG_ZERO_C;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    // A non-decimal nibble yields a dark digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Decimal +1 on a two-digit BCD value, with 99 wrapping to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = val[7:4];
        ones = val[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            if (tens >= 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // Decimal -1 on a two-digit BCD value, with 00 wrapping to 99.
    function automatic logic [7:0] bcd_dec(input logic [7:0] val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = val[7:4];
        ones = val[3:0];
        if (ones == 4'd0) begin
            ones = 4'd9;
            if (tens == 4'd0) begin
                tens = 4'd9;
            end else begin
                tens = tens - 4'd1;
            end
        end else begin
            ones = ones - 4'd1;
        end
        return {tens, ones};
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw_s;
    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] deb_r;
    logic [19:0]        deb_cnt_r [NUM_BTN];
    logic [NUM_BTN-1:0] flip_s;
    logic [NUM_BTN-1:0] press_s;
    logic [7:0]         count_r;
    logic [7:0]         count_next_s;
    logic [6:0]         seg0_r;
    logic [6:0]         seg1_r;

    assign btn_raw_s = {btn_clr, btn_dec, btn_inc};

    // Two-flop synchronizer per button; the second flop is the usable level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Flip and press detection for each button.
    // A flip happens when the level has differed from the debounced value for
    // the full window. A press is a flip that moves the debounced level from 0
    // to 1. The count therefore reacts on the same edge that d flips.
    always_comb begin
        flip_s  = 3'b000;
        press_s = 3'b000;
        for (int i = 0; i < NUM_BTN; i++) begin
            if ((sync2_r[i] != deb_r[i]) && (deb_cnt_r[i] == DEB_LAST_C)) begin
                flip_s[i]  = 1'b1;
                press_s[i] = ~deb_r[i];
            end else begin
                flip_s[i]  = 1'b0;
                press_s[i] = 1'b0;
            end
        end
    end

    // Debounce state for each button: the accepted level and its stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_r <= 3'b000;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_r[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= 20'd0;
                end else if (flip_s[i]) begin
                    deb_r[i]     <= ~deb_r[i];
                    deb_cnt_r[i] <= 20'd0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 20'd1;
                end
            end
        end
    end

    // Next score value: clear wins; inc and dec together cancel each other.
    always_comb begin
        count_next_s = count_r;
        if (press_s[BTN_CLR]) begin
            count_next_s = 8'h00;
        end else if (press_s[BTN_INC] && press_s[BTN_DEC]) begin
            count_next_s = count_r;
        end else if (press_s[BTN_INC]) begin
            count_next_s = bcd_inc(count_r);
        end else if (press_s[BTN_DEC]) begin
            count_next_s = bcd_dec(count_r);
        end else begin
            count_next_s = count_r;
        end
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'h00;
        end else begin
            count_r <= count_next_s;
        end
    end

    // Segment registers, one cycle behind the score register.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg0_r <= SEG_ZERO_C;
            seg1_r <= SEG1_RST_C;
        end else begin
            seg0_r <= seg_encode(count_r[3:0]);
            if ((BLANK_LEADING != 0) && (count_r[7:4] == 4'd0)) begin
                seg1_r <= SEG_BLANK_C;
            end else begin
                seg1_r <= seg_encode(count_r[7:4]);
            end
        end
    end

    assign count = count_r;
    assign seg0  = seg0_r;
    assign seg1  = seg1_r;

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive cycles a synchronized button level must hold before it is accepted (legal range 1..2^20-1).
REQ-002 The block SHALL have parameter BLANK_LEADING, default 1, meaning a tens digit of 0 is blanked when 1.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 The block SHALL have port btn_inc  input  1  raw asynchronous increment button, high = pressed.
REQ-006 The block SHALL have port btn_dec  input  1  raw asynchronous decrement button, high = pressed.
REQ-007 The block SHALL have port btn_clr  input  1  raw asynchronous clear button, high = pressed.
REQ-008 The block SHALL have port count  output  8  registered BCD value {tens[3:0], ones[3:0]}, 00..99.
REQ-009 The block SHALL have port seg0  output  7  registered ones-digit pattern {g,f,e,d,c,b,a}, active-low, feeding display mux seg0.
REQ-010 The block SHALL have port seg1  output  7  registered tens-digit pattern, same format, feeding display mux seg1.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer; sync output s = second flop.
REQ-012 Each button SHALL keep a debounced level d (reset 0) and a 20-bit counter c (reset 0): c cleared whenever s == d; when s != d and c == DEBOUNCE_CYCLES-1, d flips and c clears; otherwise c increments.
REQ-013 A press event SHALL be the single cycle in which d flips 0->1; release (1->0) SHALL generate no event; holding a button SHALL generate exactly one event.
REQ-014 With a raw button held high from the first sampling edge E1, count SHALL update on edge E(DEBOUNCE_CYCLES+2) and seg0/seg1 SHALL reflect it one edge later.
REQ-015 A high pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.
REQ-016 Event priority within one cycle: clr -> count 00; else inc and dec together -> no change; else inc -> +1; else dec -> -1.
REQ-017 Arithmetic SHALL be decimal BCD: ones 9+1 -> 0 with tens carry; 99+1 -> 00; 00-1 -> 99; ones 0-1 -> 9 with tens borrow; no nibble SHALL ever hold A..F.
REQ-018 Segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 seg0 SHALL always show the ones digit; seg1 SHALL be 1111111 when BLANK_LEADING=1 and tens==0, else the tens pattern.
REQ-020 seg0/seg1 SHALL be registered from count, giving exactly one cycle latency count -> segments.

Reset
REQ-021 While reset is high at a clk edge, all synchronizer flops, d, c SHALL be 0, count SHALL be 8'h00, seg0 SHALL be 1000000, seg1 SHALL be 1111111 (BLANK_LEADING=1) or 1000000 (BLANK_LEADING=0).
REQ-022 Reset asserted mid-debounce SHALL discard the pending transition; a button still held after reset deasserts SHALL be re-debounced from zero and produce one event.
REQ-023 No output SHALL change on an edge where reset is low and no event occurs.

Verification (DEBOUNCE_CYCLES=4, BLANK_LEADING=1)
REQ-024 Reset, then btn_inc held high from edge E1 -> count 00 through E5, count 01 at E6, seg0 1111001 at E7, seg1 stays 1111111.
REQ-025 btn_inc glitch high 3 cycles, low 3 cycles, repeated 10 times -> count remains 00, seg0 remains 1000000.
REQ-026 From count 99 apply one inc press -> count 00; then one dec press -> count 99, seg1 0010000, seg0 0010000.
REQ-027 From count 09 one inc -> 10, seg1 1111001, seg0 1000000; one dec -> 09, seg1 1111111.
REQ-028 btn_inc and btn_dec raised on the same edge from count 42 -> count stays 42; btn_clr raised together with btn_inc from 42 -> count 00.
REQ-029 btn_dec held, reset pulsed 1 cycle at E3, btn_dec still held -> count 00 after reset, then 99 exactly DEBOUNCE_CYCLES+2 edges after reset release edge; no second decrement while held.
